// File: rtl/ras_pkg.sv
// Shared defaults and state encoding for the return-address-stack controller.
package ras_pkg;

  localparam int RAS_DEPTH       = 16;
  localparam int RAS_ADDR_W      = 32;
  localparam int RAS_INSTR_BYTES = 4;
  localparam int OVF_W           = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWAP  = 2'd1,
    ST_DRAIN = 2'd2
  } ras_state_t;

endpackage

// File: rtl/ras_sat_cnt.sv
// Saturating event counter: increments on inc, sticks at all-ones.
module sat_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
    return (&v) ? v : v + W'(1);
  endfunction

  // Count events; value is only cleared by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (inc) begin
      count <= sat_inc(count);
    end
  end

endmodule

// File: rtl/ras_ctrl.sv
// Return-address-stack controller: turns call/return events into registered
// push/pop strobes for an external stack, predicts return targets, tracks
// occupancy, and drains the stack on flush.
import ras_pkg::*;

module ras_ctrl #(
  parameter int DEPTH       = RAS_DEPTH,
  parameter int ADDR_W      = RAS_ADDR_W,
  parameter int INSTR_BYTES = RAS_INSTR_BYTES
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ev_valid,
  output logic                       ev_ready,
  input  logic                       ev_call,
  input  logic                       ev_ret,
  input  logic [ADDR_W-1:0]          ev_pc,
  input  logic                       flush,
  output logic                       flush_done,
  output logic                       stk_push,
  output logic                       stk_pop,
  output logic [ADDR_W-1:0]          stk_addr,
  input  logic [ADDR_W-1:0]          stk_top,
  output logic                       pred_valid,
  output logic [ADDR_W-1:0]          pred_target,
  output logic [$clog2(DEPTH):0]     depth,
  output logic [OVF_W-1:0]           ovf_cnt
);

  localparam int DW = $clog2(DEPTH) + 1;

  ras_state_t        state;
  logic              flush_pend;
  logic [ADDR_W-1:0] swap_addr;
  logic              accept;
  logic              full;
  logic              empty;
  logic              ovf_inc;
  logic [ADDR_W-1:0] ret_addr;

  // Events are only taken in IDLE, and a pending flush blocks them.
  assign ev_ready = (state == ST_IDLE) && !flush_pend;
  assign accept   = ev_valid && ev_ready;
  assign full     = (depth == DW'(DEPTH));
  assign empty    = (depth == '0);
  assign ret_addr = ev_pc + ADDR_W'(INSTR_BYTES);

  // Dropped calls (stack full) and returns that find the stack empty.
  assign ovf_inc  = accept && ((ev_call && !ev_ret && full) || (ev_ret && empty));

  sat_cnt #(.W(OVF_W)) u_ovf_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (ovf_inc),
    .count (ovf_cnt)
  );

  // Controller FSM with registered strobes, prediction and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      flush_pend  <= 1'b0;
      depth       <= '0;
      swap_addr   <= '0;
      stk_push    <= 1'b0;
      stk_pop     <= 1'b0;
      stk_addr    <= '0;
      pred_valid  <= 1'b0;
      pred_target <= '0;
      flush_done  <= 1'b0;
    end else begin
      stk_push   <= 1'b0;
      stk_pop    <= 1'b0;
      pred_valid <= 1'b0;
      flush_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (flush_pend) begin
            // A flush arriving this same cycle is folded into this drain.
            flush_pend <= 1'b0;
            state      <= ST_DRAIN;
          end else begin
            if (flush) begin
              flush_pend <= 1'b1;
            end
            if (accept) begin
              // Any return with a non-empty stack pops and predicts.
              if (ev_ret && !empty) begin
                stk_pop     <= 1'b1;
                pred_valid  <= 1'b1;
                pred_target <= stk_top;
              end
              if (ev_call && ev_ret) begin
                // Push is deferred one cycle so it never collides with the pop.
                swap_addr <= ret_addr;
                state     <= ST_SWAP;
                if (!empty) begin
                  depth <= depth - DW'(1);
                end
              end else if (ev_call) begin
                if (!full) begin
                  stk_push <= 1'b1;
                  stk_addr <= ret_addr;
                  depth    <= depth + DW'(1);
                end
              end else if (ev_ret && !empty) begin
                depth <= depth - DW'(1);
              end
            end
          end
        end
        ST_SWAP: begin
          // The pop freed a slot (or the stack was empty), so the push always fits.
          stk_push <= 1'b1;
          stk_addr <= swap_addr;
          depth    <= depth + DW'(1);
          state    <= ST_IDLE;
          if (flush) begin
            flush_pend <= 1'b1;
          end
        end
        ST_DRAIN: begin
          // Further flush requests are absorbed while draining.
          if (!empty) begin
            stk_pop <= 1'b1;
            depth   <= depth - DW'(1);
          end else begin
            flush_done <= 1'b1;
            state      <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ras_ctrl.sv
// Directed testbench for ras_ctrl with a simple behavioural stack model.
module tb_ras_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        ev_valid;
  logic        ev_ready;
  logic        ev_call;
  logic        ev_ret;
  logic [31:0] ev_pc;
  logic        flush;
  logic        flush_done;
  logic        stk_push;
  logic        stk_pop;
  logic [31:0] stk_addr;
  logic [31:0] stk_top;
  logic        pred_valid;
  logic [31:0] pred_target;
  logic [4:0]  depth;
  logic [7:0]  ovf_cnt;

  int tests = 0;
  int fails = 0;

  logic [31:0] mem [0:31];
  int          sp;

  always #5 clk = ~clk;

  ras_ctrl #(.DEPTH(16), .ADDR_W(32), .INSTR_BYTES(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .ev_valid    (ev_valid),
    .ev_ready    (ev_ready),
    .ev_call     (ev_call),
    .ev_ret      (ev_ret),
    .ev_pc       (ev_pc),
    .flush       (flush),
    .flush_done  (flush_done),
    .stk_push    (stk_push),
    .stk_pop     (stk_pop),
    .stk_addr    (stk_addr),
    .stk_top     (stk_top),
    .pred_valid  (pred_valid),
    .pred_target (pred_target),
    .depth       (depth),
    .ovf_cnt     (ovf_cnt)
  );

  // External stack model driven by the DUT strobes.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      sp <= 0;
    end else if (stk_pop && sp > 0) begin
      sp <= sp - 1;
    end else if (stk_push && sp < 32) begin
      mem[sp] <= stk_addr;
      sp      <= sp + 1;
    end
  end

  assign stk_top = (sp > 0) ? mem[sp-1] : 32'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offer one event for one cycle; returns at the negedge after acceptance.
  task automatic ev(input logic c, input logic r, input logic [31:0] pc);
    @(negedge clk);
    chk("ev_ready_at_offer", 32'(ev_ready), 32'h1);
    ev_valid = 1'b1;
    ev_call  = c;
    ev_ret   = r;
    ev_pc    = pc;
    @(negedge clk);
    ev_valid = 1'b0;
    ev_call  = 1'b0;
    ev_ret   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pops;
    int dones;
    int pushes;
    int both;
    int first_pop;
    int last_pop;
    int seen;

    reset    = 1'b1;
    ev_valid = 1'b0;
    ev_call  = 1'b0;
    ev_ret   = 1'b0;
    ev_pc    = 32'h0;
    flush    = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_push",   32'(stk_push),   32'h0);
    chk("rst_pop",    32'(stk_pop),    32'h0);
    chk("rst_pred",   32'(pred_valid), 32'h0);
    chk("rst_done",   32'(flush_done), 32'h0);
    chk("rst_depth",  32'(depth),      32'h0);
    chk("rst_ovf",    32'(ovf_cnt),    32'h0);
    chk("rst_addr",   stk_addr,        32'h0);
    chk("rst_target", pred_target,     32'h0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready",  32'(ev_ready),   32'h1);

    // Three calls
    ev(1'b1, 1'b0, 32'h100);
    chk("call1_push", 32'(stk_push), 32'h1);
    chk("call1_addr", stk_addr,      32'h104);
    chk("call1_pop",  32'(stk_pop),  32'h0);
    ev(1'b1, 1'b0, 32'h200);
    chk("call2_addr", stk_addr,      32'h204);
    ev(1'b1, 1'b0, 32'h300);
    chk("call3_push", 32'(stk_push), 32'h1);
    chk("call3_addr", stk_addr,      32'h304);
    chk("call3_depth", 32'(depth),   32'h3);

    // Event with neither call nor return is ignored
    ev(1'b0, 1'b0, 32'h999);
    chk("nop_push",  32'(stk_push),   32'h0);
    chk("nop_pop",   32'(stk_pop),    32'h0);
    chk("nop_pred",  32'(pred_valid), 32'h0);
    chk("nop_depth", 32'(depth),      32'h3);

    // Return predicts the top of stack
    ev(1'b0, 1'b1, 32'h0);
    chk("ret_pred",   32'(pred_valid), 32'h1);
    chk("ret_target", pred_target,     32'h304);
    chk("ret_pop",    32'(stk_pop),    32'h1);
    chk("ret_push",   32'(stk_push),   32'h0);
    chk("ret_depth",  32'(depth),      32'h2);
    @(negedge clk);
    chk("ret_pred_pulse", 32'(pred_valid), 32'h0);
    chk("ret_pop_pulse",  32'(stk_pop),    32'h0);

    // Call+return at depth 2
    ev(1'b1, 1'b1, 32'h400);
    chk("swap_n1_pop",    32'(stk_pop),    32'h1);
    chk("swap_n1_pred",   32'(pred_valid), 32'h1);
    chk("swap_n1_target", pred_target,     32'h204);
    chk("swap_n1_push",   32'(stk_push),   32'h0);
    chk("swap_n1_ready",  32'(ev_ready),   32'h0);
    chk("swap_n1_depth",  32'(depth),      32'h1);
    @(negedge clk);
    chk("swap_n2_push",   32'(stk_push),   32'h1);
    chk("swap_n2_addr",   stk_addr,        32'h404);
    chk("swap_n2_pop",    32'(stk_pop),    32'h0);
    chk("swap_n2_depth",  32'(depth),      32'h2);
    chk("swap_n2_ready",  32'(ev_ready),   32'h1);

    // Build depth 5, then flush during a swap
    ev(1'b1, 1'b0, 32'h500);
    ev(1'b1, 1'b0, 32'h600);
    ev(1'b1, 1'b0, 32'h700);
    chk("pre_flush_depth", 32'(depth), 32'h5);
    ev(1'b1, 1'b1, 32'h800);
    flush = 1'b1;
    chk("fswap_pop",    32'(stk_pop),  32'h1);
    chk("fswap_target", pred_target,   32'h704);
    chk("fswap_depth",  32'(depth),    32'h4);
    @(negedge clk);
    flush = 1'b0;
    chk("fswap_push",   32'(stk_push), 32'h1);
    chk("fswap_addr",   stk_addr,      32'h804);
    chk("fswap_depth5", 32'(depth),    32'h5);
    chk("fswap_ready",  32'(ev_ready), 32'h0);
    pops = 0; dones = 0; pushes = 0; both = 0; first_pop = -1; last_pop = -1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (stk_pop) begin
        pops++;
        if (first_pop < 0) first_pop = c;
        last_pop = c;
      end
      if (stk_push) pushes++;
      if (stk_push && stk_pop) both++;
      if (flush_done) dones++;
      flush = (c == 2);
    end
    flush = 1'b0;
    chk("drain_pops",        32'(pops),               32'd5);
    chk("drain_consecutive", 32'(last_pop - first_pop), 32'd4);
    chk("drain_pushes",      32'(pushes),             32'd0);
    chk("drain_both",        32'(both),               32'd0);
    chk("drain_done_once",   32'(dones),              32'd1);
    chk("drain_depth",       32'(depth),              32'h0);

    // 17 calls from empty: last one overflows
    pushes = 0;
    for (int i = 0; i < 17; i++) begin
      ev(1'b1, 1'b0, 32'h1000 + 32'(i) * 32'h10);
      if (stk_push) pushes++;
    end
    chk("full_pushes", 32'(pushes),  32'd16);
    chk("full_ovf",    32'(ovf_cnt), 32'd1);
    chk("full_depth",  32'(depth),   32'd16);

    // Empty the stack with a flush
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    seen = 0;
    for (int c = 0; c < 40 && seen == 0; c++) begin
      @(negedge clk);
      if (flush_done) seen = 1;
    end
    chk("flush16_done_seen", 32'(seen),  32'h1);
    chk("flush16_depth",     32'(depth), 32'h0);

    // Return at depth 0
    ev(1'b0, 1'b1, 32'h0);
    chk("ret0_pop",   32'(stk_pop),    32'h0);
    chk("ret0_pred",  32'(pred_valid), 32'h0);
    chk("ret0_ovf",   32'(ovf_cnt),    32'd2);
    chk("ret0_depth", 32'(depth),      32'h0);

    // Flush at depth 0: done two cycles after the pending flag is set
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush0_done_c1", 32'(flush_done), 32'h0);
    @(negedge clk);
    chk("flush0_done_c2", 32'(flush_done), 32'h0);
    @(negedge clk);
    chk("flush0_done_c3", 32'(flush_done), 32'h1);
    @(negedge clk);
    chk("flush0_done_c4", 32'(flush_done), 32'h0);

    // Call+return at depth 0
    ev(1'b1, 1'b1, 32'h900);
    chk("swap0_pop",   32'(stk_pop),    32'h0);
    chk("swap0_pred",  32'(pred_valid), 32'h0);
    chk("swap0_ovf",   32'(ovf_cnt),    32'd3);
    chk("swap0_ready", 32'(ev_ready),   32'h0);
    @(negedge clk);
    chk("swap0_push",  32'(stk_push),   32'h1);
    chk("swap0_addr",  stk_addr,        32'h904);
    chk("swap0_depth", 32'(depth),      32'h1);

    // Saturation of the overflow counter
    ev_valid = 1'b1;
    ev_ret   = 1'b1;
    repeat (260) @(negedge clk);
    ev_valid = 1'b0;
    ev_ret   = 1'b0;
    chk("sat_ovf",   32'(ovf_cnt), 32'd255);
    chk("sat_depth", 32'(depth),   32'h0);
    @(negedge clk);
    chk("sat_hold",  32'(ovf_cnt), 32'd255);

    // Reset in the middle of a drain
    ev(1'b1, 1'b0, 32'ha00);
    ev(1'b1, 1'b0, 32'hb00);
    ev(1'b1, 1'b0, 32'hc00);
    chk("mid_pre_depth", 32'(depth), 32'h3);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    seen = 0;
    for (int c = 0; c < 10 && seen == 0; c++) begin
      @(negedge clk);
      if (stk_pop) seen = 1;
    end
    chk("mid_drain_started", 32'(seen), 32'h1);
    reset = 1'b1;
    #1;
    chk("mid_rst_pop",    32'(stk_pop),    32'h0);
    chk("mid_rst_push",   32'(stk_push),   32'h0);
    chk("mid_rst_pred",   32'(pred_valid), 32'h0);
    chk("mid_rst_done",   32'(flush_done), 32'h0);
    chk("mid_rst_depth",  32'(depth),      32'h0);
    chk("mid_rst_ovf",    32'(ovf_cnt),    32'h0);
    chk("mid_rst_addr",   stk_addr,        32'h0);
    chk("mid_rst_target", pred_target,     32'h0);
    @(negedge clk);
    reset = 1'b0;
    pops = 0; dones = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (stk_pop) pops++;
      if (flush_done) dones++;
    end
    chk("post_rst_pops",  32'(pops),     32'd0);
    chk("post_rst_done",  32'(dones),    32'd0);
    chk("post_rst_ready", 32'(ev_ready), 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
